// File: rtl/spm_page_writer_pkg.sv
// Shared definitions for the SPM page writer.
// Holds the FSM state encoding, the default geometry and erase value,
// and the page-size helper used by the writer and its page buffer.
package spm_page_writer_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int ADDR_W_DEF    = 13;
    localparam int PAGE_W_DEF    = 6;

    // Value an erased program word reads back as. It is also the clear value of the buffer.
    localparam logic [WORD_SIZE_DEF-1:0] ERASE_VAL_DEF = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ERASE = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    function automatic int page_words(input int page_w);
        return 1 << page_w;
    endfunction

    localparam int PAGE_WORDS_DEF = page_words(PAGE_W_DEF);

endpackage

// File: rtl/spm_page_buf.sv
// One-page temporary buffer for the SPM writer.
// Ports:
//   clk_i, rst_ni      clock and async active-low reset (reset fills with ERASE_VAL)
//   we_i/waddr_i/wdata_i  single write port
//   clr_i              synchronous clear of every word to ERASE_VAL (wins over we_i)
//   raddr_i/rdata_o    asynchronous read port
module spm_page_buf
    import spm_page_writer_pkg::*;
#(
    parameter int                   WORD_SIZE = WORD_SIZE_DEF,
    parameter int                   PAGE_W    = PAGE_W_DEF,
    parameter logic [WORD_SIZE-1:0] ERASE_VAL = '1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [PAGE_W-1:0]    waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic                 clr_i,
    input  logic [PAGE_W-1:0]    raddr_i,
    output logic [WORD_SIZE-1:0] rdata_o
);

    localparam int DEPTH = page_words(PAGE_W);

    logic [DEPTH-1:0][WORD_SIZE-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (clr_i) begin
            mem_d = {DEPTH{ERASE_VAL}};
        end else if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= {DEPTH{ERASE_VAL}};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spm_page_writer.sv
// Self-programming page writer: initiator of the program memory write port.
// The CPU fills a one-page buffer, then requests a page erase or page write;
// the page is streamed to program memory at one word per clock.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   fill_i/off_i/data_i           buffer fill request
//   erase_i, write_i, page_i      page commands (page sampled at accept)
//   busy_o, done_o, rej_o         status: op running, completion pulse, dropped-request pulse
//   pm_addr_o/pm_data_o/pm_we_o   program memory write port (all registered)
module spm_page_writer
    import spm_page_writer_pkg::*;
#(
    parameter int                   WORD_SIZE = WORD_SIZE_DEF,
    parameter int                   ADDR_W    = ADDR_W_DEF,
    parameter int                   PAGE_W    = PAGE_W_DEF,
    parameter logic [WORD_SIZE-1:0] ERASE_VAL = '1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     fill_i,
    input  logic                     erase_i,
    input  logic                     write_i,
    input  logic [ADDR_W-PAGE_W-1:0] page_i,
    input  logic [PAGE_W-1:0]        off_i,
    input  logic [WORD_SIZE-1:0]     data_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rej_o,
    output logic [ADDR_W-1:0]        pm_addr_o,
    output logic [WORD_SIZE-1:0]     pm_data_o,
    output logic                     pm_we_o
);

    localparam int                PG_W     = ADDR_W - PAGE_W;
    localparam logic [PAGE_W-1:0] LAST_OFF = '1;

    logic [1:0]           state_q, state_d;
    logic [PG_W-1:0]      page_q, page_d;
    logic [PAGE_W-1:0]    off_q, off_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rej_q, rej_d;
    logic                 pm_we_q, pm_we_d;
    logic [ADDR_W-1:0]    pm_addr_q, pm_addr_d;
    logic [WORD_SIZE-1:0] pm_data_q, pm_data_d;

    logic                 buf_we, buf_clr;
    logic [PAGE_W-1:0]    rd_off, next_off;
    logic [WORD_SIZE-1:0] rd_data;

    // off_q is the offset currently on the PM port; the buffer is read one word
    // ahead so that the registered data lines up with the registered address.
    // PAGE_W-bit add: wraps inside the page, never carries into the page field.
    assign next_off = off_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        off_d     = off_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rej_d     = 1'b0;
        pm_we_d   = pm_we_q;
        pm_addr_d = pm_addr_q;
        pm_data_d = pm_data_q;
        buf_we    = 1'b0;
        buf_clr   = 1'b0;
        rd_off    = next_off;

        case (state_q)
            ST_IDLE: begin
                rd_off = '0;
                if (erase_i || write_i) begin
                    state_d   = erase_i ? ST_ERASE : ST_WRITE;
                    page_d    = page_i;
                    off_d     = '0;
                    busy_d    = 1'b1;
                    pm_we_d   = 1'b1;
                    pm_addr_d = {page_i, {PAGE_W{1'b0}}};
                    pm_data_d = erase_i ? ERASE_VAL : rd_data;
                    rej_d     = fill_i || (erase_i && write_i);
                end else if (fill_i) begin
                    buf_we = 1'b1;
                end
            end
            ST_ERASE, ST_WRITE: begin
                rej_d = fill_i || erase_i || write_i;
                if (off_q == LAST_OFF) begin
                    // The edge after the last word ends the op; a write also
                    // clears the buffer on that same edge.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    pm_we_d = 1'b0;
                    done_d  = 1'b1;
                    buf_clr = (state_q == ST_WRITE);
                end else begin
                    off_d     = next_off;
                    pm_addr_d = {page_q, next_off};
                    pm_data_d = (state_q == ST_WRITE) ? rd_data : ERASE_VAL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                pm_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            page_q    <= '0;
            off_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rej_q     <= 1'b0;
            pm_we_q   <= 1'b0;
            pm_addr_q <= '0;
            pm_data_q <= '0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            off_q     <= off_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rej_q     <= rej_d;
            pm_we_q   <= pm_we_d;
            pm_addr_q <= pm_addr_d;
            pm_data_q <= pm_data_d;
        end
    end

    spm_page_buf #(
        .WORD_SIZE (WORD_SIZE),
        .PAGE_W    (PAGE_W),
        .ERASE_VAL (ERASE_VAL)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (buf_we),
        .waddr_i (off_i),
        .wdata_i (data_i),
        .clr_i   (buf_clr),
        .raddr_i (rd_off),
        .rdata_o (rd_data)
    );

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rej_o     = rej_q;
    assign pm_we_o   = pm_we_q;
    assign pm_addr_o = pm_addr_q;
    assign pm_data_o = pm_data_q;

endmodule

// File: tb/tb_spm_page_writer.sv
// Bench for spm_page_writer: a monitor collects every PM write and status
// pulse; a page-level model (buffer array + expected page image) predicts them.
module tb_spm_page_writer;

    localparam int WS  = 16;
    localparam int AW  = 13;
    localparam int PW  = 6;
    localparam int NW  = 64;
    localparam int PGW = AW - PW;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           fill_i = 1'b0, erase_i = 1'b0, write_i = 1'b0;
    logic [PGW-1:0] page_i = '0;
    logic [PW-1:0]  off_i = '0;
    logic [WS-1:0]  data_i = '0;
    logic           busy_o, done_o, rej_o, pm_we_o;
    logic [AW-1:0]  pm_addr_o;
    logic [WS-1:0]  pm_data_o;

    spm_page_writer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .fill_i(fill_i), .erase_i(erase_i),
        .write_i(write_i), .page_i(page_i), .off_i(off_i), .data_i(data_i),
        .busy_o(busy_o), .done_o(done_o), .rej_o(rej_o),
        .pm_addr_o(pm_addr_o), .pm_data_o(pm_data_o), .pm_we_o(pm_we_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [WS-1:0] d;
    } wr_t;

    wr_t wq[$];
    int  busy_cnt = 0, done_cnt = 0, rej_cnt = 0;

    always @(negedge clk_i) begin
        if (pm_we_o === 1'b1) wq.push_back('{cyc, pm_addr_o, pm_data_o});
        if (busy_o === 1'b1) busy_cnt++;
        if (done_o === 1'b1) done_cnt++;
        if (rej_o === 1'b1) rej_cnt++;
    end

    // Page-level model state
    logic [WS-1:0]  buf_m[NW];
    logic [WS-1:0]  exp_m[NW];
    logic [PGW-1:0] exp_page;
    int             exp_cyc;
    int             exp_rej;

    task automatic model_clear();
        for (int i = 0; i < NW; i++) buf_m[i] = 16'hFFFF;
    endtask

    // All tasks start and end at a negedge (or just after one).
    task automatic do_fill(input int off, input logic [WS-1:0] d);
        fill_i = 1'b1; off_i = PW'(off); data_i = d;
        @(negedge clk_i);
        fill_i = 1'b0;
        buf_m[off] = d;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) do_fill($urandom_range(0, NW - 1), WS'($urandom));
    endtask

    task automatic start_cmd(input bit er, input bit wr, input bit fl, input int page);
        wq.delete();
        busy_cnt = 0; done_cnt = 0; rej_cnt = 0;
        exp_page = PGW'(page);
        exp_cyc  = cyc + 1;
        exp_rej  = (fl || (er && wr)) ? 1 : 0;
        if (er) begin
            for (int i = 0; i < NW; i++) exp_m[i] = 16'hFFFF;
        end else begin
            for (int i = 0; i < NW; i++) exp_m[i] = buf_m[i];
            model_clear();
        end
        erase_i = er; write_i = wr; fill_i = fl; page_i = PGW'(page);
        off_i = PW'($urandom); data_i = WS'($urandom);
        @(negedge clk_i);
        erase_i = 1'b0; write_i = 1'b0; fill_i = 1'b0;
        page_i = PGW'($urandom);  // must be ignored while busy
    endtask

    task automatic finish_op(input string nm);
        int w = 0;
        while (done_o !== 1'b1 && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        #1;
        total++;
        if (w >= 200) begin
            bad++;
            $display("FAIL %s timeout: done_o not seen within 200 cycles", nm);
            return;
        end
        total++;
        if (pm_we_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s done_cycle: pm_we_o=%b busy_o=%b required 0 0", nm, pm_we_o, busy_o);
        end
        total++;
        if (wq.size() != NW || busy_cnt != NW || done_cnt != 1 || rej_cnt != exp_rej) begin
            bad++;
            $display("FAIL %s counts: words=%0d busy=%0d done=%0d rej=%0d required %0d %0d 1 %0d",
                     nm, wq.size(), busy_cnt, done_cnt, rej_cnt, NW, NW, exp_rej);
        end
        for (int k = 0; k < NW && k < wq.size(); k++) begin
            logic [AW-1:0] ea;
            ea = {exp_page, PW'(k)};
            total++;
            if (wq[k].a !== ea || wq[k].d !== exp_m[k] || wq[k].c != exp_cyc + k) begin
                bad++;
                $display("FAIL %s word%0d: addr=%h data=%h cyc=%0d required %h %h %0d",
                         nm, k, wq[k].a, wq[k].d, wq[k].c, ea, exp_m[k], exp_cyc + k);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        total++;
        if ({busy_o, done_o, rej_o, pm_we_o} !== 4'b0 || pm_addr_o !== '0 || pm_data_o !== '0) begin
            bad++;
            $display("FAIL reset_values: b/d/r/we=%b addr=%h data=%h required 0", {busy_o, done_o, rej_o, pm_we_o}, pm_addr_o, pm_data_o);
        end
        rst_ni = 1'b1;
        model_clear();
        wq.delete();
        repeat (5) begin
            @(negedge clk_i);
            total++;
            if ({busy_o, done_o, rej_o, pm_we_o} !== 4'b0) begin
                bad++;
                $display("FAIL idle_outputs: b/d/r/we=%b required 0000", {busy_o, done_o, rej_o, pm_we_o});
            end
        end
        total++;
        if (wq.size() != 0) begin
            bad++;
            $display("FAIL idle_no_we: writes=%0d required 0", wq.size());
        end
    endtask

    // Full page write, then a second write accepted in the done cycle.
    task automatic test_write_back_to_back();
        for (int i = 0; i < NW; i++) do_fill(i, WS'(16'h1000 + i));
        start_cmd(1'b0, 1'b1, 1'b0, 3);
        finish_op("write_p3");
        start_cmd(1'b0, 1'b1, 1'b0, 4);
        finish_op("write_p4_after_done");
    endtask

    task automatic test_erase_keeps_buffer();
        fill_rand(8);
        do_fill(5, 16'hABCD);
        start_cmd(1'b1, 1'b0, 1'b0, 127);
        finish_op("erase_p127");
        start_cmd(1'b0, 1'b1, 1'b0, 1);
        finish_op("write_p1");
    endtask

    task automatic test_conflicts();
        fill_rand(6);
        start_cmd(1'b1, 1'b1, 1'b0, $urandom_range(0, 127));
        finish_op("erase_vs_write");
        fill_rand(4);
        start_cmd(1'b0, 1'b1, 1'b1, $urandom_range(0, 127));
        finish_op("write_vs_fill");
        fill_rand(5);
        start_cmd(1'b1, 1'b0, 1'b0, $urandom_range(0, 127));
        repeat (10) @(negedge clk_i);
        fill_i = 1'b1; off_i = PW'($urandom); data_i = WS'($urandom);
        exp_rej = 1;
        @(negedge clk_i);
        fill_i = 1'b0;
        finish_op("fill_while_busy");
        start_cmd(1'b0, 1'b1, 1'b0, $urandom_range(0, 127));
        finish_op("write_after_busy_fill");
    endtask

    task automatic test_reset_mid();
        fill_rand(10);
        start_cmd(1'b0, 1'b1, 1'b0, $urandom_range(0, 127));
        repeat (20) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if (pm_we_o !== 1'b0 || busy_o !== 1'b0 || pm_addr_o !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: we=%b busy=%b addr=%h required 0 0 0", pm_we_o, busy_o, pm_addr_o);
        end
        total++;
        if (wq.size() != 21) begin
            bad++;
            $display("FAIL reset_mid_words: words=%0d required 21", wq.size());
        end
        for (int k = 0; k < 21 && k < wq.size(); k++) begin
            total++;
            if (wq[k].a !== {exp_page, PW'(k)} || wq[k].d !== exp_m[k]) begin
                bad++;
                $display("FAIL reset_mid_word%0d: addr=%h data=%h required %h %h", k, wq[k].a, wq[k].d, {exp_page, PW'(k)}, exp_m[k]);
            end
        end
        model_clear();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        start_cmd(1'b0, 1'b1, 1'b0, 0);
        finish_op("write_p0_after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            bit er;
            fill_rand($urandom_range(0, 20));
            er = 1'($urandom);
            start_cmd(er, ~er, 1'b0, $urandom_range(0, 127));
            finish_op(er ? "rand_erase" : "rand_write");
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk_i);
        test_reset();
        test_write_back_to_back();
        test_erase_keeps_buffer();
        test_conflicts();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
